// File: rtl/writeback_regfile_pkg.sv
// Shared constants and helpers for the write-back stage and register file.
// Build option: WB_BYPASS_EN selects write-through reads in the top level.
package writeback_regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int NUM_REGS = 32;

  // Encoding of the MEM/WB memToReg field (WB[0]).
  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wbSel_e;

  function automatic logic isMemSel(input logic memToReg);
    return wbSel_e'(memToReg) == WB_SEL_MEM;
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB fields, ID-stage read ports and write-back observation signals.
// Master drives the pipeline fields and read indices; slave is the register file.
interface writeback_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);

  logic [DATA_W-1:0] memoryWord;
  logic [DATA_W-1:0] aluResult;
  logic [ADDR_W-1:0] RD;
  logic              regWrite;
  logic              memToReg;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] writeData;
  logic [CNT_W-1:0]  writeCount;

  modport master (
    output memoryWord, aluResult, RD, regWrite, memToReg, readReg1, readReg2,
    input  readData1, readData2, writeData, writeCount
  );

  modport slave (
    input  memoryWord, aluResult, RD, regWrite, memToReg, readReg1, readReg2,
    output readData1, readData2, writeData, writeCount
  );

endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// Storage array: 2 asynchronous read ports, 1 synchronous write port, synchronous clear.
// Reads are zero latency; writes land on the next rising edge; never stalls.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeValue,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readValue1,
  output logic [DATA_W-1:0] readValue2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (writeEn) begin
      mem[writeAddr] <= writeValue;
    end
  end

  assign readValue1 = mem[readAddr1];
  assign readValue2 = mem[readAddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back mux, zero-register guard, optional bypass (WB_BYPASS_EN) and commit counter.
// Latency: writeData/readData combinational, commit on next edge; no handshake, never stalls MEM/WB.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                clock,
  input  logic                reset,
  writeback_regfile_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              commit;
  logic [DATA_W-1:0] wbValue;
  logic [DATA_W-1:0] rawData1;
  logic [DATA_W-1:0] rawData2;
  logic [CNT_W-1:0]  commitCount;

  always_comb begin
    wbValue = bus.aluResult;
    if (isMemSel(bus.memToReg)) begin
      wbValue = bus.memoryWord;
    end
  end

  // Writes to register 0 are discarded entirely, including from the counter.
  assign commit        = bus.regWrite && (bus.RD != ZERO_IDX);
  assign bus.writeData = wbValue;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clock      (clock),
    .reset      (reset),
    .writeEn    (commit),
    .writeAddr  (bus.RD),
    .writeValue (wbValue),
    .readAddr1  (bus.readReg1),
    .readAddr2  (bus.readReg2),
    .readValue1 (rawData1),
    .readValue2 (rawData2)
  );

  function automatic logic [DATA_W-1:0] portValue(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] bypassValue
  );
    logic [DATA_W-1:0] result;
    result = stored;
    if (idx == ZERO_IDX) begin
      result = '0;
    end else if (hit) begin
      result = bypassValue;
    end
    return result;
  endfunction

  logic hit1;
  logic hit2;

`ifdef WB_BYPASS_EN
  // Same-cycle write-through so ID sees the value being committed now.
  assign hit1 = commit && (bus.readReg1 == bus.RD);
  assign hit2 = commit && (bus.readReg2 == bus.RD);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    bus.readData1 = portValue(bus.readReg1, rawData1, hit1, wbValue);
    bus.readData2 = portValue(bus.readReg2, rawData2, hit2, wbValue);
  end

  // Free-running modulo counter of retired writes; wraps silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      commitCount <= '0;
    end else if (commit) begin
      commitCount <= commitCount + CNT_W'(1);
    end
  end

  assign bus.writeCount = commitCount;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed and randomized checks of writeback_regfile against an array-based model.
module tb_writeback_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  logic [31:0] model [32];
  int          modelCount = 0;

  writeback_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  writeback_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelWb();
    return bus.memToReg ? bus.memoryWord : bus.aluResult;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (bus.regWrite && bus.RD != 5'd0 && idx == bus.RD) return modelWb();
`endif
    return model[idx];
  endfunction

  // Architectural state: what the register file must hold after each edge.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      modelCount = 0;
    end else if (bus.regWrite && bus.RD != 5'd0) begin
      model[bus.RD] = modelWb();
      modelCount++;
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      check("rnd_writeData", bus.writeData, modelWb());
      check("rnd_readData1", bus.readData1, modelRead(bus.readReg1));
      check("rnd_readData2", bus.readData2, modelRead(bus.readReg2));
      check("rnd_writeCount", 32'(bus.writeCount), 32'(modelCount % (1 << CNT_W)));
    end
  end

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.memoryWord = '0;
    bus.aluResult  = '0;
    bus.RD         = '0;
    bus.regWrite   = 1'b0;
    bus.memToReg   = 1'b0;
    bus.readReg1   = '0;
    bus.readReg2   = '0;

    stepCycle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.readReg1 = 5'(i);
      bus.readReg2 = 5'(31 - i);
      #1;
      check("reset_read1", bus.readData1, 32'd0);
      check("reset_read2", bus.readData2, 32'd0);
    end
    check("reset_count", 32'(bus.writeCount), 32'd0);

    bus.regWrite  = 1'b1;
    bus.memToReg  = 1'b0;
    bus.aluResult = 32'h1234_5678;
    bus.memoryWord = 32'h0BAD_F00D;
    bus.RD        = 5'd5;
    #1;
    check("alu_sel_writeData", bus.writeData, 32'h1234_5678);
    stepCycle();
    bus.regWrite = 1'b0;
    bus.readReg1 = 5'd5;
    #1;
    check("write_r5", bus.readData1, 32'h1234_5678);
    check("count_after_r5", 32'(bus.writeCount), 32'd1);

    bus.regWrite   = 1'b1;
    bus.memToReg   = 1'b1;
    bus.memoryWord = 32'hDEAD_BEEF;
    bus.RD         = 5'd0;
    bus.readReg2   = 5'd0;
    #1;
    check("mem_sel_writeData", bus.writeData, 32'hDEAD_BEEF);
    stepCycle();
    bus.regWrite = 1'b0;
    #1;
    check("r0_stays_zero", bus.readData2, 32'd0);
    check("r0_no_count", 32'(bus.writeCount), 32'd1);

    bus.regWrite  = 1'b1;
    bus.memToReg  = 1'b0;
    bus.aluResult = 32'h0000_00A5;
    bus.RD        = 5'd7;
    bus.readReg1  = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("hazard_before_edge", bus.readData1, 32'h0000_00A5);
`else
    check("hazard_before_edge", bus.readData1, 32'd0);
`endif
    stepCycle();
    bus.regWrite = 1'b0;
    #1;
    check("hazard_after_edge", bus.readData1, 32'h0000_00A5);
    check("count_after_r7", 32'(bus.writeCount), 32'd2);

    bus.regWrite  = 1'b1;
    bus.aluResult = 32'h0000_0099;
    bus.RD        = 5'd3;
    reset         = 1'b1;
    stepCycle();
    reset        = 1'b0;
    bus.regWrite = 1'b0;
    bus.readReg1 = 5'd3;
    bus.readReg2 = 5'd5;
    #1;
    check("reset_drops_write", bus.readData1, 32'd0);
    check("reset_clears_r5", bus.readData2, 32'd0);
    check("reset_clears_count", 32'(bus.writeCount), 32'd0);

    bus.regWrite = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.RD        = 5'(1 + (i % 31));
      bus.aluResult = $urandom;
      stepCycle();
    end
    bus.regWrite = 1'b0;
    #1;
    check("count_at_max", 32'(bus.writeCount), 32'd15);
    bus.regWrite = 1'b1;
    bus.RD       = 5'd9;
    stepCycle();
    bus.regWrite = 1'b0;
    #1;
    check("count_wraps", 32'(bus.writeCount), 32'd0);

    checkEn = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.regWrite   = ($urandom_range(0, 3) != 0);
      bus.memToReg   = $urandom_range(0, 1) == 1;
      bus.memoryWord = $urandom;
      bus.aluResult  = $urandom;
      bus.RD         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.readReg1   = ($urandom_range(0, 2) == 0) ? bus.RD : 5'($urandom_range(0, 31));
      bus.readReg2   = ($urandom_range(0, 3) == 0) ? bus.readReg1 : 5'($urandom_range(0, 31));
      stepCycle();
    end
    checkEn = 1'b0;
    reset   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
